// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are all zero.
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;
  state_t             state, state_nx;
  logic [2*WIDTH-1:0] mcand, acc, prod;
  logic [WIDTH-1:0]   mplier, mplier_nx, mag_a, mag_b;
  logic [CW-1:0]      cnt;
  logic               neg, sel_hi, sign_a, sign_b, accept, last;
  // Operand sign/magnitude conditioning, final sign fix-up and loop-exit detection
  always_comb begin
    sign_a    = a_i[WIDTH-1] & ((op_i == 2'b01) | (op_i == 2'b10));
    sign_b    = b_i[WIDTH-1] & (op_i == 2'b01);
    mag_a     = sign_a ? -a_i : a_i;
    mag_b     = sign_b ? -b_i : b_i;
    accept    = start_i & ~flush_i;
    mplier_nx = mplier >> 1;
    prod      = neg ? -acc : acc;
`ifdef SEQ_MUL_EARLY_TERM_EN
    last      = (cnt == CW'(WIDTH - 1)) | (mplier_nx == '0);
`else
    last      = cnt == CW'(WIDTH - 1);
`endif
  end
  // Next-state logic; flush always returns to IDLE without a done pulse
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? CALC : IDLE;
      CALC:    state_nx = flush_i ? IDLE : (last ? FIN : CALC);
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_o = (state == CALC) | (state == FIN);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // Datapath: capture in IDLE, one partial product per CALC cycle, result/done on FIN exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      sel_hi   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= (state == FIN) & ~flush_i;
      if (state == IDLE && accept) begin
        mcand  <= {{WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= '0;
        neg    <= sign_a ^ sign_b;
        sel_hi <= op_i != 2'b00;
      end else if (state == CALC) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier_nx;
        cnt    <= cnt + 1'b1;
      end else if (state == FIN && !flush_i) begin
        result_o <= sel_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      end
    end
  end
endmodule
